fifo_sync_param: RTL and testbench

- Parametrised synchronous FIFO; next generation of the team's fixed 8x32 sync FIFO.
- Adds configurable width and depth, an occupancy count, and programmable almost-full/almost-empty flags.
- Adds a read-valid strobe, sticky overflow/underflow error flags, and accepted read+write when full.
- Sits between single-clock producer/consumer blocks behind a chip-select.

---
 rtl/fifo_pkg.sv | 34 +++
 rtl/fifo_mem_2p.sv | 39 +++
 rtl/fifo_sync_param.sv | 152 +++++++++++++++
 tb/tb_fifo_sync_param.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO family.
package fifo_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_DEPTH  = 8;

    // Ceiling log2, usable in parameter/localparam expressions.
    function automatic int fifo_clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        return result;
    endfunction

    // Occupancy from two wrap-bit pointers of ptr_w bits: the difference
    // taken modulo 2**ptr_w, which stays correct across pointer wrap.
    function automatic logic [31:0] fifo_occupancy(
        input logic [31:0] wr_ptr,
        input logic [31:0] rd_ptr,
        input int          ptr_w
    );
        logic [31:0] diff;
        logic [31:0] mask;
        diff = wr_ptr - rd_ptr;
        mask = (32'd1 << ptr_w) - 32'd1;
        return diff & mask;
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Storage array for the FIFO: one synchronous write port and one registered
// read port. Contents and read register are deliberately not reset.
module fifo_mem_2p
    import fifo_pkg::*;
#(
    parameter int  DATA_W = DEFAULT_DATA_W,
    parameter int  DEPTH  = DEFAULT_DEPTH,
    localparam int ADDR_W = fifo_clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // Write port: store the incoming word at the write address.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read port: capture the addressed word; a same-cycle write to that slot
    // is not visible here, so the old contents are returned.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, read-valid strobe and sticky errors.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int  DATA_W   = DEFAULT_DATA_W,
    parameter int  DEPTH    = DEFAULT_DEPTH,
    parameter int  AF_LEVEL = DEPTH - 2,
    parameter int  AE_LEVEL = 2,
    localparam int ADDR_W   = fifo_clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              err_clr,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int             PTR_W    = ADDR_W + 1;
    localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [ADDR_W:0] FULL_LVL = PTR_W'(DEPTH);
    localparam logic [ADDR_W:0] AF_LVL   = PTR_W'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_LVL   = PTR_W'(AE_LEVEL);

    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic              rd_valid_q, rd_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              data_seen_q, data_seen_d;

    logic [ADDR_W:0]   count_s;
    logic              empty_s;
    logic              full_s;
    logic              rd_acc_s;
    logic              wr_acc_s;
    logic [DATA_W-1:0] mem_rd_data_s;

    // Occupancy is the wrap-aware pointer difference; flags decode it directly.
    assign count_s = PTR_W'(fifo_occupancy(32'(wr_ptr_q), 32'(rd_ptr_q), PTR_W));
    assign empty_s = (count_s == PTR_ZERO);
    assign full_s  = (count_s == FULL_LVL);

    // Request acceptance; reset suppresses every access so memory is untouched.
    always_comb begin
        rd_acc_s = 1'b0;
        wr_acc_s = 1'b0;
        if (rst) begin
            rd_acc_s = 1'b0;
            wr_acc_s = 1'b0;
        end else begin
            rd_acc_s = cs & rd_en & ~empty_s;
            wr_acc_s = cs & wr_en & (~full_s | rd_acc_s);
        end
    end

    // Next-state for pointers, read strobe and sticky error flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rd_valid_d  = rd_acc_s;
        data_seen_d = data_seen_q | rd_acc_s;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_acc_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        // A new error event in the clear cycle takes priority over the clear.
        if (cs & wr_en & ~wr_acc_s) begin
            overflow_d = 1'b1;
        end else if (err_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        if (cs & rd_en & empty_s) begin
            underflow_d = 1'b1;
        end else if (err_clr) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= PTR_ZERO;
            rd_ptr_q    <= PTR_ZERO;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            data_seen_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            data_seen_q <= data_seen_d;
        end
    end

    fifo_mem_2p #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc_s),
        .wr_addr (wr_ptr_q[ADDR_W-1:0]),
        .wr_data (data_in),
        .rd_en   (rd_acc_s),
        .rd_addr (rd_ptr_q[ADDR_W-1:0]),
        .rd_data (mem_rd_data_s)
    );

    // The memory read register has no reset, so data_out reads as zero until
    // the first accepted read after reset refreshes it.
    assign data_out     = mem_rd_data_s & {DATA_W{data_seen_q}};
    assign rd_valid     = rd_valid_q;
    assign empty        = empty_s;
    assign full         = full_s;
    assign almost_empty = (count_s <= AE_LVL);
    assign almost_full  = (count_s >= AF_LVL);
    assign count        = count_s;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_fifo_sync_param;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int AF_LVL = 6;
    localparam int AE_LVL = 2;

    logic              clk;
    logic              rst;
    logic              cs;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] data_in;
    logic              err_clr;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic              almost_empty;
    logic              almost_full;
    logic [3:0]        count;
    logic              overflow;
    logic              underflow;

    fifo_sync_param #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LVL),
        .AE_LEVEL (AE_LVL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cs           (cs),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .data_in      (data_in),
        .err_clr      (err_clr),
        .data_out     (data_out),
        .rd_valid     (rd_valid),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [DATA_W-1:0] mq[$];
    logic [DATA_W-1:0] exp_dout;
    logic              exp_rv;
    logic              exp_ovf;
    logic              exp_udf;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        n = mq.size();
        check_eq("count",        32'(count),        32'(n));
        check_eq("empty",        32'(empty),        32'(n == 0));
        check_eq("full",         32'(full),         32'(n == DEPTH));
        check_eq("almost_empty", 32'(almost_empty), 32'(n <= AE_LVL));
        check_eq("almost_full",  32'(almost_full),  32'(n >= AF_LVL));
        check_eq("data_out",     data_out,          exp_dout);
        check_eq("rd_valid",     32'(rd_valid),     32'(exp_rv));
        check_eq("overflow",     32'(overflow),     32'(exp_ovf));
        check_eq("underflow",    32'(underflow),    32'(exp_udf));
    endtask

    // Apply one cycle of inputs, advance the model by the FIFO rules, check.
    task automatic step(input logic i_cs, input logic i_wr, input logic i_rd,
                        input logic [DATA_W-1:0] i_din, input logic i_clr, input logic i_rst);
        logic rd_ok;
        logic wr_ok;
        cs      = i_cs;
        wr_en   = i_wr;
        rd_en   = i_rd;
        data_in = i_din;
        err_clr = i_clr;
        rst     = i_rst;
        @(posedge clk);
        if (i_rst) begin
            mq.delete();
            exp_dout = '0;
            exp_rv   = 1'b0;
            exp_ovf  = 1'b0;
            exp_udf  = 1'b0;
        end else begin
            rd_ok = i_cs && i_rd && (mq.size() > 0);
            wr_ok = i_cs && i_wr && ((mq.size() < DEPTH) || rd_ok);
            if (i_cs && i_wr && !wr_ok)           exp_ovf = 1'b1;
            else if (i_clr)                       exp_ovf = 1'b0;
            if (i_cs && i_rd && mq.size() == 0)   exp_udf = 1'b1;
            else if (i_clr)                       exp_udf = 1'b0;
            if (rd_ok) exp_dout = mq.pop_front();
            if (wr_ok) mq.push_back(i_din);
            exp_rv = rd_ok;
        end
        #1;
        check_all();
    endtask

    task automatic wr(input logic [DATA_W-1:0] d);
        step(1'b1, 1'b1, 1'b0, d, 1'b0, 1'b0);
    endtask

    task automatic rd();
        step(1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        mq.delete();
        exp_dout = '0;
        exp_rv   = 1'b0;
        exp_ovf  = 1'b0;
        exp_udf  = 1'b0;

        // Reset, then fill 1..8 and overflow with a ninth write
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 1; i <= 8; i++) wr(32'(i));
        check_eq("full_after_8", 32'(full), 32'd1);
        wr(32'h0000_0009);
        check_eq("ovf_9th_write", 32'(overflow), 32'd1);

        // Drain 8 and underflow with a ninth read
        for (int i = 1; i <= 8; i++) rd();
        rd();
        check_eq("hold_after_udf", data_out, 32'h0000_0008);
        check_eq("udf_9th_read", 32'(underflow), 32'd1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

        // Full plus simultaneous read and write
        for (int i = 1; i <= 8; i++) wr(32'(i));
        step(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        check_eq("rw_full_dout", data_out, 32'h0000_0001);
        check_eq("rw_full_count", 32'(count), 32'd8);
        for (int i = 0; i < 7; i++) rd();
        rd();
        check_eq("rw_full_last", data_out, 32'hDEAD_BEEF);

        // Empty plus simultaneous read and write
        step(1'b1, 1'b1, 1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0);
        check_eq("rw_empty_count", 32'(count), 32'd1);
        check_eq("rw_empty_rv", 32'(rd_valid), 32'd0);
        rd();
        check_eq("rw_empty_read", data_out, 32'hA5A5_A5A5);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

        // Wrap-around with interleaved single write/read
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) wr(32'h0000_0100 + 32'(i));
            else            rd();
        end

        // Chip-select low on a full FIFO, then reset and error clear
        for (int i = 1; i <= 8; i++) wr(32'h0000_1000 + 32'(i));
        step(1'b0, 1'b1, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
        check_eq("cs_low_count", 32'(count), 32'd8);
        wr(32'h0000_0BAD);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0C0D, 1'b0, 1'b1);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_dout", data_out, 32'h0);
        rd();
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check_eq("clr_udf", 32'(underflow), 32'd0);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 9) != 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 $urandom(),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 99) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
